// File: rtl/mask_frame_scheduler_pkg.sv
// Shared constants and types for the binned-mask ping-pong frame store.
package mask_frame_scheduler_pkg;

  localparam int unsigned BIN_HRES   = 80;
  localparam int unsigned BIN_VRES   = 45;
  localparam int unsigned DATA_WIDTH = 1;
  localparam int unsigned RD_LATENCY = 2;

  localparam int unsigned HCW    = $clog2(BIN_HRES);
  localparam int unsigned VCW    = $clog2(BIN_VRES);
  localparam int unsigned ADDR_W = $clog2(BIN_HRES * BIN_VRES);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic bank_t;

  typedef struct packed {
    logic  id;
    bank_t bank;
  } rd_tag_t;

  typedef enum logic {
    PtrC0 = 1'b0,
    PtrC1 = 1'b1
  } rr_ptr_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [HCW-1:0] h,
                                                 input logic [VCW-1:0] v);
    return ADDR_W'(v) * ADDR_W'(BIN_HRES) + ADDR_W'(h);
  endfunction

endpackage

// File: rtl/mask_frame_scheduler_if.sv
// Writer stream, consumer read ports and status of the mask frame store.
interface mask_frame_scheduler_if;
  import mask_frame_scheduler_pkg::*;

  logic [HCW-1:0]        hcount_in;
  logic [VCW-1:0]        vcount_in;
  logic [DATA_WIDTH-1:0] pixel_data_in;
  logic                  data_valid_in;
  logic                  lock_in;
  logic [1:0]            rd_req_in;
  logic [1:0][HCW-1:0]   rd_hcount_in;
  logic [1:0][VCW-1:0]   rd_vcount_in;
  logic [1:0]            rd_grant_out;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic [1:0]            rd_valid_out;
  logic                  frame_valid_out;
  logic                  swap_out;
  logic [7:0]            dropped_out;

  modport master (
    output hcount_in, vcount_in, pixel_data_in, data_valid_in, lock_in,
    output rd_req_in, rd_hcount_in, rd_vcount_in,
    input  rd_grant_out, rd_data_out, rd_valid_out, frame_valid_out, swap_out, dropped_out
  );

  modport slave (
    input  hcount_in, vcount_in, pixel_data_in, data_valid_in, lock_in,
    input  rd_req_in, rd_hcount_in, rd_vcount_in,
    output rd_grant_out, rd_data_out, rd_valid_out, frame_valid_out, swap_out, dropped_out
  );

endinterface

// File: rtl/mask_frame_scheduler_rr_arbiter.sv
// Two-way round-robin arbiter; on contention the consumer not granted last time wins.
module mask_frame_scheduler_rr_arbiter
  import mask_frame_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  rr_ptr_e ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PtrC0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (ptr_q == PtrC0) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    if (grant_o[0]) begin
      ptr_d = PtrC0;
    end else if (grant_o[1]) begin
      ptr_d = PtrC1;
    end
  end

endmodule

// File: rtl/mask_frame_scheduler.sv
// Ping-pong binned-mask frame store: the stream writes one bank while two arbitrated
// consumers read the other; banks swap at end of frame unless the consumers hold a lock.
module mask_frame_scheduler
  import mask_frame_scheduler_pkg::*;
(
  input logic                   clk_in,
  input logic                   rst_in,
  mask_frame_scheduler_if.slave bus_io
);

  logic                  in_range, is_eof, wr_accept;
  logic                  wr_valid_q, wr_eof_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  bank_t                 wr_bank_q;
  logic                  swap_q, frame_valid_q;
  logic [7:0]            dropped_q;

  logic [DATA_WIDTH-1:0] bank0_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_q [DEPTH];

  logic [1:0]            grant;
  logic                  grant_id;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic [RD_LATENCY-1:0] rd_vld_q;
  rd_tag_t               rd_tag_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rd_data_q [RD_LATENCY-1];

  assign in_range  = (bus_io.hcount_in < HCW'(BIN_HRES)) && (bus_io.vcount_in < VCW'(BIN_VRES));
  assign is_eof    = (bus_io.hcount_in == HCW'(BIN_HRES - 1)) &&
                     (bus_io.vcount_in == VCW'(BIN_VRES - 1));
  assign wr_accept = bus_io.data_valid_in && in_range;

  // Write stage; the bank toggles one cycle after the end-of-frame write issues.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_valid_q    <= 1'b0;
      wr_eof_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      swap_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      dropped_q     <= '0;
    end else begin
      wr_valid_q <= wr_accept;
      wr_eof_q   <= wr_accept && is_eof;
      wr_addr_q  <= pix_addr(bus_io.hcount_in, bus_io.vcount_in);
      wr_data_q  <= bus_io.pixel_data_in;
      swap_q     <= 1'b0;
      if (wr_eof_q && !bus_io.lock_in) begin
        wr_bank_q     <= ~wr_bank_q;
        swap_q        <= 1'b1;
        frame_valid_q <= 1'b1;
      end else if (wr_eof_q && (dropped_q != 8'hFF)) begin
        dropped_q <= dropped_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_valid_q && (wr_bank_q == 1'b0)) bank0_q[wr_addr_q] <= wr_data_q;
    if (wr_valid_q && (wr_bank_q == 1'b1)) bank1_q[wr_addr_q] <= wr_data_q;
  end

  mask_frame_scheduler_rr_arbiter u_arb (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .req_i   (bus_io.rd_req_in),
    .grant_o (grant)
  );

  assign grant_id = grant[1];

  // Each read carries the bank it was granted against, so a swap never redirects it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_vld_q  <= '0;
      rd_addr_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_tag_q[i] <= '0;
      for (int i = 0; i < RD_LATENCY - 1; i++) rd_data_q[i] <= '0;
    end else begin
      rd_vld_q    <= {rd_vld_q[RD_LATENCY-2:0], |grant};
      rd_tag_q[0] <= '{id: grant_id, bank: ~wr_bank_q};
      for (int i = 1; i < RD_LATENCY; i++) rd_tag_q[i] <= rd_tag_q[i-1];
      rd_addr_q   <= pix_addr(bus_io.rd_hcount_in[grant_id], bus_io.rd_vcount_in[grant_id]);
      if (rd_vld_q[0]) begin
        rd_data_q[0] <= rd_tag_q[0].bank ? bank1_q[rd_addr_q] : bank0_q[rd_addr_q];
      end
      for (int i = 1; i < RD_LATENCY - 1; i++) rd_data_q[i] <= rd_data_q[i-1];
    end
  end

  always_comb begin
    bus_io.rd_valid_out = 2'b00;
    if (rd_vld_q[RD_LATENCY-1]) begin
      bus_io.rd_valid_out[rd_tag_q[RD_LATENCY-1].id] = 1'b1;
    end
  end

  assign bus_io.rd_grant_out    = grant;
  assign bus_io.rd_data_out     = rd_data_q[RD_LATENCY-2];
  assign bus_io.frame_valid_out = frame_valid_q;
  assign bus_io.swap_out        = swap_q;
  assign bus_io.dropped_out     = dropped_q;

endmodule
